status_vector_ctrl: RTL and testbench
=====================================

STATUS_VECTOR_CTRL -- requirements
Module: status_vector_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of status vector entries, at least 2.
REQ-002 Parameter WIDTH, default 2: status value width in bits.
REQ-003 Parameter NREQ, default 2: number of push requesters, at least 1.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 push_req_i  input  NREQ  per-requester push request.
REQ-007 push_value_i  input  NREQ*WIDTH  per-requester value; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 push_gnt_o  output  NREQ  one-hot grant; the push is accepted in the same cycle.
REQ-009 pull_req_i  input  1  request to retire the oldest entry.
REQ-010 pull_ack_o  output  1  pull accepted this cycle.
REQ-011 flush_i  input  1  level request to drain the vector.
REQ-012 push_o, pull_o  output  1 each  registered push and pull commands to the status vector.
REQ-013 value_o  output  WIDTH  registered value that accompanies push_o.
REQ-014 empty_o  output  1  registered flag, to the vector's empty_i; high when the vector holds no entries.
REQ-015 valid_mask_o  output  DEPTH  thermometer of the entries held by the vector.
REQ-016 count_o  output  $clog2(DEPTH+1)  number of accepted entries.
REQ-017 full_o  output  1  count_o equals DEPTH.
REQ-018 busy_o  output  1  high while the FSM is in FLUSH.

Function
REQ-019 A pull SHALL be accepted when pull_req_i is high, count_o is greater than 0, and the FSM is in RUN.
REQ-020 A push SHALL be accepted when any push_req_i bit is high, the FSM is in RUN, and either count_o is less than DEPTH or a pull is accepted in the same cycle.
REQ-021 When count_o is 0, push and pull SHALL never be accepted together, because a pull is not accepted at zero count.
REQ-022 Push arbitration SHALL be round-robin: the priority pointer moves to the granted index plus 1 (mod NREQ) only when a push is accepted.
REQ-023 Accepted operations SHALL appear on push_o, pull_o and value_o one cycle after acceptance; these outputs are high for one cycle per accepted operation.
REQ-024 count_o SHALL update at the acceptance edge: +1 for push only, -1 for pull only, unchanged for both; it never leaves the range 0..DEPTH.
REQ-025 valid_mask_o and empty_o SHALL be aligned with the vector contents, one cycle behind count_o: bit i of valid_mask_o is high when i is less than the delayed count.
REQ-026 The FSM SHALL have two states, RUN and FLUSH.
REQ-027 RUN to FLUSH: flush_i high while in RUN.
REQ-028 In FLUSH, pushes are blocked and one internal pull is issued per cycle while count_o is greater than 0; pull_ack_o stays low.
REQ-029 FLUSH to RUN: count_o equals 0 and flush_i is low; while flush_i stays high, the FSM remains in FLUSH with count_o at 0.

Reset
REQ-030 While rst_i is high, at the clock edge: push_o, pull_o, value_o, count_o, valid_mask_o, full_o and busy_o SHALL reset to 0, empty_o to 1, the FSM to RUN, and the arbitration pointer to index 0.
REQ-031 Reset asserted mid-flush or mid-operation SHALL discard all in-flight commands; no push_o or pull_o is issued in the cycle after reset.

Configuration
REQ-032 Macro STATUS_VECTOR_SET_LAST_EN SHALL control the set-last feature.
REQ-033 With STATUS_VECTOR_SET_LAST_EN defined, the block adds inputs set_req_i (1 bit) and set_value_i (WIDTH bits) and outputs set_o and set_value_o, both registered with one-cycle latency.
REQ-034 With the macro defined, set_req_i is honoured only when count_o is greater than 0 and the FSM is in RUN.
REQ-035 Without STATUS_VECTOR_SET_LAST_EN, those four ports SHALL be absent and the vector SHALL be built with SET_EN=0.

Structure
REQ-036 A shared package status_vector_pkg SHALL hold the FSM state typedef (RUN, FLUSH), the push/pull encoding constants NN, NP, PN and PP, and the count-width function.
REQ-037 The round-robin arbiter SHALL be a sub-module named status_vector_rr_arb, with parameter NREQ, combinational grant output, and a registered pointer updated on an accept strobe.

Verification
REQ-038 Scenario, push until full: DEPTH=8, requester 0 pushes 9 cycles -> 8 grants, count_o=8, full_o=1, 9th request gets no grant, valid_mask_o=8'hFF one cycle later.
REQ-039 Scenario, push and pull at full: count_o=8, push and pull requested together -> both accepted, count_o stays 8, push_o and pull_o high in the next cycle.
REQ-040 Scenario, fairness: NREQ=2, both requesters held high for 4 cycles -> grants 01,10,01,10.
REQ-041 Scenario, flush: count_o=5, flush_i pulsed for 1 cycle -> busy_o high, 5 consecutive pull_o, then RUN with empty_o=1; push requests during the flush get no grant.
REQ-042 Scenario, reset mid-flush: rst_i asserted at count_o=3 during FLUSH -> next cycle count_o=0, empty_o=1, busy_o=0, no pull_o issued.
REQ-043 Scenario, set-last (macro defined): count_o=0 with set_req_i high -> set_o stays low; count_o=2 with set_req_i high -> set_o=1 one cycle later.

Source files
------------

// File: rtl/status_vector_pkg.sv
// Shared definitions for the status vector controller: FSM state type,
// push/pull command encodings and the count-width helper.
// Optional feature macro: STATUS_VECTOR_SET_LAST_EN (set-last command path).
package status_vector_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // {push, pull} command pairs as seen by the count update
  localparam logic [1:0] NN = 2'b00;
  localparam logic [1:0] NP = 2'b01;
  localparam logic [1:0] PN = 2'b10;
  localparam logic [1:0] PP = 2'b11;

  // Set-last support of the downstream vector follows the build option
`ifdef STATUS_VECTOR_SET_LAST_EN
  localparam bit SET_EN = 1'b1;
`else
  localparam bit SET_EN = 1'b0;
`endif

  // Bits needed to hold a count in the range 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/status_vector_ctrl_if.sv
// Requester-side handshake bundle of the status vector controller.
// master: the requesters (drive requests); slave: the controller.
interface status_vector_ctrl_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 2
);

  logic [NREQ-1:0]       push_req_i;
  logic [NREQ*WIDTH-1:0] push_value_i;
  logic [NREQ-1:0]       push_gnt_o;
  logic                  pull_req_i;
  logic                  pull_ack_o;
  logic                  flush_i;

  modport master (
    output push_req_i,
    output push_value_i,
    output pull_req_i,
    output flush_i,
    input  push_gnt_o,
    input  pull_ack_o
  );

  modport slave (
    input  push_req_i,
    input  push_value_i,
    input  pull_req_i,
    input  flush_i,
    output push_gnt_o,
    output pull_ack_o
  );

endinterface

// File: rtl/status_vector_rr_arb.sv
// Round-robin arbiter for the push requesters. The grant is combinational;
// the priority pointer only advances (to granted index + 1) on accept_i.
module status_vector_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            accept_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int unsigned N  = NREQ;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Search requesters starting at the pointer; first one found wins
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Priority pointer register, moved only when the push is taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/status_vector_ctrl.sv
// Status vector controller: arbitrates pushes, accepts pulls, tracks the
// entry count and drives registered push/pull commands to the vector.
// A level flush request drains the vector one entry per cycle.
// Optional feature macro: STATUS_VECTOR_SET_LAST_EN adds the set-last path
// (set_req_i/set_value_i in, set_o/set_value_o out).
module status_vector_ctrl
  import status_vector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int NREQ  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  status_vector_ctrl_if.slave           bus,
  output logic                          push_o,
  output logic                          pull_o,
  output logic [WIDTH-1:0]              value_o,
  output logic                          empty_o,
  output logic [DEPTH-1:0]              valid_mask_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o,
  output logic                          full_o,
  output logic                          busy_o
`ifdef STATUS_VECTOR_SET_LAST_EN
  ,
  input  logic                          set_req_i,
  input  logic [WIDTH-1:0]              set_value_i,
  output logic                          set_o,
  output logic [WIDTH-1:0]              set_value_o
`endif
);

  localparam int unsigned      CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

  state_e            state_q;
  state_e            state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [NREQ-1:0]   arb_gnt;
  logic              push_acc;
  logic              pull_acc;
  logic              flush_pull;
  logic              pull_do;
  logic [WIDTH-1:0]  push_val;
  logic [DEPTH-1:0]  mask_d;

  status_vector_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (bus.push_req_i),
    .accept_i (push_acc),
    .gnt_o    (arb_gnt)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and acceptance decisions
  always_comb begin
    state_d    = state_q;
    pull_acc   = 1'b0;
    push_acc   = 1'b0;
    flush_pull = 1'b0;
    unique case (state_q)
      RUN: begin
        pull_acc = bus.pull_req_i && (cnt_q != '0);
        // A same-cycle pull frees the slot, so a full vector still takes a push
        push_acc = (|bus.push_req_i) && ((cnt_q < DEPTH_C) || pull_acc);
        if (bus.flush_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_pull = (cnt_q != '0);
        if ((cnt_q == '0) && !bus.flush_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pull_do        = pull_acc | flush_pull;
  assign bus.push_gnt_o = push_acc ? arb_gnt : '0;
  assign bus.pull_ack_o = pull_acc;

  // Value of the granted requester
  always_comb begin
    push_val = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        push_val = bus.push_value_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Count update from the accepted push/pull pair
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_acc, pull_do})
      PN:     cnt_d = cnt_q + CW'(1);
      NP:     cnt_d = cnt_q - CW'(1);
      NN, PP: cnt_d = cnt_q;
    endcase
  end

  // Thermometer of the current count, registered to follow the vector
  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mask_d[i] = (CW'(i) < cnt_q);
    end
  end

  // Registered commands, count and vector-aligned occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      push_o       <= 1'b0;
      pull_o       <= 1'b0;
      value_o      <= '0;
      cnt_q        <= '0;
      valid_mask_o <= '0;
      empty_o      <= 1'b1;
    end else begin
      push_o       <= push_acc;
      pull_o       <= pull_do;
      value_o      <= push_acc ? push_val : '0;
      cnt_q        <= cnt_d;
      valid_mask_o <= mask_d;
      empty_o      <= (cnt_q == '0);
    end
  end

  assign count_o = cnt_q;
  assign full_o  = (cnt_q == DEPTH_C);
  assign busy_o  = (state_q == FLUSH);

`ifdef STATUS_VECTOR_SET_LAST_EN
  logic set_ok;
  assign set_ok = SET_EN && set_req_i && (cnt_q != '0) && (state_q == RUN);

  // Registered set-last command, only while entries exist and not flushing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      set_o       <= 1'b0;
      set_value_o <= '0;
    end else begin
      set_o       <= set_ok;
      set_value_o <= set_ok ? set_value_i : '0;
    end
  end
`endif

endmodule

// File: tb/tb_status_vector_ctrl.sv
// Scoreboard bench for status_vector_ctrl: a count/flag reference model
// predicts grants, acceptances and the command stream; a separate monitor
// pops expected commands whenever push_o or pull_o is presented.
module tb_status_vector_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 2;
  localparam int NREQ  = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = NREQ * WIDTH;

  typedef struct {
    bit               push;
    bit               pull;
    logic [WIDTH-1:0] val;
    int               cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  status_vector_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic             push_o, pull_o, empty_o, full_o, busy_o;
  logic [WIDTH-1:0] value_o;
  logic [DEPTH-1:0] valid_mask_o;
  logic [CW-1:0]    count_o;
`ifdef STATUS_VECTOR_SET_LAST_EN
  logic             set_req = 1'b0;
  logic [WIDTH-1:0] set_value = '0;
  logic             set_o;
  logic [WIDTH-1:0] set_value_o;
`endif

  status_vector_ctrl #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .push_o       (push_o),
    .pull_o       (pull_o),
    .value_o      (value_o),
    .empty_o      (empty_o),
    .valid_mask_o (valid_mask_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .busy_o       (busy_o)
`ifdef STATUS_VECTOR_SET_LAST_EN
    ,
    .set_req_i    (set_req),
    .set_value_i  (set_value),
    .set_o        (set_o),
    .set_value_o  (set_value_o)
`endif
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  ev_t scb[$];

  // reference model state
  int               m_cnt  = 0;
  int               m_prev = 0;
  int               m_ptr  = 0;
  bit               m_flush = 1'b0;
  bit               exp_set = 1'b0;
  logic [WIDTH-1:0] exp_setv = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model step: called before the coming edge with the inputs applied
  task automatic model_step(input bit r);
    bit               pull_ok, push_ok, int_pull, nf;
    int               g;
    logic [NREQ-1:0]  exp_gnt;
    ev_t              e;
    if (r) begin
      m_cnt = 0; m_prev = 0; m_ptr = 0; m_flush = 1'b0; exp_set = 1'b0;
      return;
    end
    check("count_o", 32'(count_o), 32'(m_cnt));
    check("full_o", 32'(full_o), 32'(m_cnt == DEPTH));
    check("busy_o", 32'(busy_o), 32'(m_flush));
    check("empty_o", 32'(empty_o), 32'(m_prev == 0));
    check("valid_mask_o", 32'(valid_mask_o), (1 << m_prev) - 1);

    pull_ok  = bus.pull_req_i && (m_cnt > 0) && !m_flush;
    push_ok  = (|bus.push_req_i) && !m_flush && ((m_cnt < DEPTH) || pull_ok);
    int_pull = m_flush && (m_cnt > 0);
    exp_gnt  = '0;
    g        = -1;
    if (push_ok) begin
      for (int i = 0; i < NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (g < 0 && bus.push_req_i[c]) g = c;
      end
      exp_gnt[g] = 1'b1;
    end
    check("push_gnt_o", 32'(bus.push_gnt_o), 32'(exp_gnt));
    check("pull_ack_o", 32'(bus.pull_ack_o), 32'(pull_ok));

    if (push_ok || pull_ok || int_pull) begin
      e.push = push_ok;
      e.pull = pull_ok || int_pull;
      e.val  = '0;
      if (push_ok) e.val = bus.push_value_i[g*WIDTH +: WIDTH];
      e.cyc  = cyc + 1;
      scb.push_back(e);
    end

`ifdef STATUS_VECTOR_SET_LAST_EN
    check("set_o", 32'(set_o), 32'(exp_set));
    if (exp_set) check("set_value_o", 32'(set_value_o), 32'(exp_setv));
    exp_set  = set_req && (m_cnt > 0) && !m_flush;
    exp_setv = set_value;
`endif

    nf = m_flush;
    if (!m_flush && bus.flush_i) nf = 1'b1;
    else if (m_flush && m_cnt == 0 && !bus.flush_i) nf = 1'b0;
    m_prev  = m_cnt;
    m_cnt   = m_cnt + int'(push_ok) - int'(pull_ok || int_pull);
    if (push_ok) m_ptr = (g + 1) % NREQ;
    m_flush = nf;
  endtask

  task automatic drive(input bit r, input logic [NREQ-1:0] preq, input bit pull, input bit fl);
    @(posedge clk);
    #2;
    rst              = r;
    bus.push_req_i   = preq;
    bus.push_value_i = VW'($urandom);
    bus.pull_req_i   = pull;
    bus.flush_i      = fl;
`ifdef STATUS_VECTOR_SET_LAST_EN
    set_req   = ($urandom_range(0, 1) == 1);
    set_value = WIDTH'($urandom);
`endif
    #2;
    model_step(r);
  endtask

  // Monitor: pop one expected command whenever the DUT presents one
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (push_o === 1'b1 || pull_o === 1'b1) begin
        if (scb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd: push_o=%0b pull_o=%0b, none expected at %0t", push_o, pull_o, $time);
        end else begin
          e = scb.pop_front();
          check("cmd_cycle", 32'(cyc), 32'(e.cyc));
          check("push_o", 32'(push_o), 32'(e.push));
          check("pull_o", 32'(pull_o), 32'(e.pull));
          if (e.push) check("value_o", 32'(value_o), 32'(e.val));
        end
      end
    end
  end

  initial begin
    int k;
    bus.push_req_i   = '0;
    bus.push_value_i = '0;
    bus.pull_req_i   = 1'b0;
    bus.flush_i      = 1'b0;

    drive(1'b1, '0, 1'b0, 1'b0);
    drive(1'b1, '0, 1'b0, 1'b0);

    // push until full with requester 0
    repeat (9) drive(1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("full_count", 32'(count_o), 32'd8);
    check("full_flag", 32'(full_o), 32'd1);
    check("full_mask", 32'(valid_mask_o), 32'hFF);

    // push and pull together at full
    drive(1'b0, 2'b01, 1'b1, 1'b0);
    check("pp_pull_ack", 32'(bus.pull_ack_o), 32'd1);
    check("pp_gnt", 32'(bus.push_gnt_o), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("pp_count", 32'(count_o), 32'd8);
    check("pp_push_o", 32'(push_o), 32'd1);
    check("pp_pull_o", 32'(pull_o), 32'd1);

    // drain, including one pull at zero count
    repeat (9) drive(1'b0, '0, 1'b1, 1'b0);

    // fairness from a fresh pointer
    drive(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, 1'b0, 1'b0);
      check("fair_gnt", 32'(bus.push_gnt_o), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // flush from count 5, pushes blocked meanwhile
    drive(1'b0, 2'b10, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b11, 1'b1, 1'b0);
      check("flush_busy", 32'(busy_o), 32'd1);
      check("flush_no_gnt", 32'(bus.push_gnt_o), 32'd0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("flush_done_busy", 32'(busy_o), 32'd0);
    check("flush_done_empty", 32'(empty_o), 32'd1);

    // reset in the middle of a flush
    repeat (6) drive(1'b0, 2'b01, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    k = 0;
    while (!(m_cnt == 3 && m_flush) && k < 10) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      k++;
    end
    drive(1'b1, '0, 1'b0, 1'b0);
    check("rstflush_count_before", 32'(count_o), 32'd3);
    check("rstflush_busy_before", 32'(busy_o), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rstflush_count", 32'(count_o), 32'd0);
    check("rstflush_empty", 32'(empty_o), 32'd1);
    check("rstflush_busy", 32'(busy_o), 32'd0);

    // randomized traffic: push-heavy first half, pull-heavy second half
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 149) == 0,
            NREQ'($urandom),
            $urandom_range(0, 99) < ((i < 300) ? 30 : 70),
            $urandom_range(0, 39) == 0);
    end

    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
